// File: rtl/snn_wb_initiator.sv
// Wishbone classic initiator: queues single-word commands and runs them one at a time against the neuron core.
// Optional SNN_WB_INIT_ERR_EN adds wbm_err_i as a bus-error termination alongside the ack timeout.
module snn_wb_initiator #(
    parameter int CMD_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
`ifdef SNN_WB_INIT_ERR_EN
    input  logic        wbm_err_i,
`endif
    input  logic        wbm_ack_i,
    output logic        busy
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state, state_next;
    cmd_t          fifo_mem [CMD_DEPTH];
    cmd_t          head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [TW-1:0] tmo_cnt;
    logic          empty, full, push, pop;
    logic          done_ok, done_err, bus_err;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign busy      = !empty || (state != IDLE);
    assign wbm_stb_o = wbm_cyc_o;

`ifdef SNN_WB_INIT_ERR_EN
    assign bus_err = wbm_err_i;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    // Ack takes priority over both error sources on the same edge.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop        = 1'b1;
                state_next = BUS;
            end
            BUS: if (wbm_ack_i) begin
                done_ok    = 1'b1;
                state_next = RESP;
            end else if (bus_err || (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
                done_err   = 1'b1;
                state_next = RESP;
            end
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tmo_cnt   <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                wbm_cyc_o <= 1'b1;
                wbm_we_o  <= head.we;
                wbm_sel_o <= head.sel;
                wbm_adr_o <= head.adr;
                wbm_dat_o <= head.dat;
                tmo_cnt   <= '0;
            end
            if (state == BUS) begin
                if (done_ok || done_err) wbm_cyc_o <= 1'b0;
                else                     tmo_cnt   <= tmo_cnt + 1'b1;
            end
            if (done_ok) begin
                rsp_valid <= 1'b1;
                rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                rsp_err   <= 1'b0;
            end
            if (done_err) begin
                rsp_valid <= 1'b1;
                rsp_dat   <= 32'h0;
                rsp_err   <= 1'b1;
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snn_wb_initiator.sv
// Directed bench for snn_wb_initiator with a small Wishbone target model (programmable ack/err latency).
module tb_snn_wb_initiator;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        busy;
`ifdef SNN_WB_INIT_ERR_EN
    logic        wbm_err_i = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    snn_wb_initiator #(.CMD_DEPTH(8), .TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
`ifdef SNN_WB_INIT_ERR_EN
        .wbm_err_i(wbm_err_i),
`endif
        .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Target model: ack (or err) after a programmed number of BUS edges.
    int          ack_lat = 0;
    int          err_lat = 99;
    int          bus_cnt = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_adr [$];
    logic [32:0] rsp_log [$];
    int          cyc_rises = 0;
    logic        cyc_d = 1'b0;

    always @(negedge wb_clk_i) begin
        if (wbm_cyc_o === 1'b1) begin
            wbm_ack_i = (bus_cnt == ack_lat);
`ifdef SNN_WB_INIT_ERR_EN
            wbm_err_i = (bus_cnt == err_lat);
`endif
            wbm_dat_i = mem.exists(wbm_adr_o) ? mem[wbm_adr_o] : 32'hDEAD_BEEF;
            bus_cnt++;
        end else begin
            wbm_ack_i = 1'b0;
`ifdef SNN_WB_INIT_ERR_EN
            wbm_err_i = 1'b0;
`endif
            wbm_dat_i = '0;
            bus_cnt   = 0;
        end
    end

    always @(posedge wb_clk_i) begin
        if (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1 && wbm_ack_i) begin
            log_adr.push_back(wbm_adr_o);
            if (wbm_we_o) mem[wbm_adr_o] = wbm_dat_o;
        end
        if (rsp_valid === 1'b1 && rsp_ready) rsp_log.push_back({rsp_err, rsp_dat});
        if (wbm_cyc_o === 1'b1 && !cyc_d) cyc_rises++;
        cyc_d = (wbm_cyc_o === 1'b1);
    end

    task automatic cycle(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat, output logic acc);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = 4'hF;
        acc = cmd_ready;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output logic ok);
        for (int i = 0; i < budget && rsp_valid !== 1'b1; i++) @(negedge wb_clk_i);
        ok = (rsp_valid === 1'b1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        cycle(1);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        cycle(3);
        checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000) begin failures++; $display("FAIL reset_ctl got %b exp 000", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
        checks++; if ({wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 68'h0) begin failures++; $display("FAIL reset_bus got %h exp 0", {wbm_sel_o, wbm_adr_o, wbm_dat_o}); end
        checks++; if ({rsp_valid, rsp_err, rsp_dat} !== 34'h0) begin failures++; $display("FAIL reset_rsp got %h exp 0", {rsp_valid, rsp_err, rsp_dat}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        wb_rst_i = 1'b0;
        cycle(1);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic test_write_read();
        logic acc, ok;
        ack_lat = 0;
        push(1'b1, 32'h3000_0010, 32'hA5A5_1234, acc);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL wr_accept got %b exp 1", acc); end
        checks++; if (wbm_cyc_o !== 1'b0) begin failures++; $display("FAIL wr_cyc_early got %b exp 0", wbm_cyc_o); end
        cycle(1);
        checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'b111_1111) begin failures++; $display("FAIL wr_launch got %b exp 1111111", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}); end
        checks++; if ({wbm_adr_o, wbm_dat_o} !== {32'h3000_0010, 32'hA5A5_1234}) begin failures++; $display("FAIL wr_bus got %h exp 30000010a5a51234", {wbm_adr_o, wbm_dat_o}); end
        cycle(1);
        checks++; if ({wbm_cyc_o, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'h0}) begin failures++; $display("FAIL wr_rsp got %h exp %h", {wbm_cyc_o, rsp_valid, rsp_err, rsp_dat}, {3'b010, 32'h0}); end
        consume();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_clear got %b exp 0", rsp_valid); end
        push(1'b0, 32'h3000_0010, 32'h0, acc);
        cycle(1);
        checks++; if ({wbm_cyc_o, wbm_we_o} !== 2'b10) begin failures++; $display("FAIL rd_launch got %b exp 10", {wbm_cyc_o, wbm_we_o}); end
        wait_rsp(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rd_rsp_timeout got none exp response"); end
        checks++; if ({rsp_err, rsp_dat} !== {1'b0, 32'hA5A5_1234}) begin failures++; $display("FAIL rd_data got %h exp 0a5a51234", {rsp_err, rsp_dat}); end
        consume();
    endtask

    task automatic test_backpressure();
        logic acc;
        int   l0, n_bad, busy_left;
        ack_lat = 0;
        rsp_ready = 1'b0;
        l0 = log_adr.size();
        rsp_log.delete();
        for (int i = 0; i < 10; i++) begin
            push(1'b1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), acc);
            checks++; if (acc !== (i < 9)) begin failures++; $display("FAIL bp_accept_%0d got %b exp %b", i, acc, (i < 9)); end
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy got %b exp 1", busy); end
        rsp_ready = 1'b1;
        busy_left = 200;
        while (busy_left > 0 && busy !== 1'b0) begin cycle(1); busy_left--; end
        rsp_ready = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_drain got busy %b exp 0", busy); end
        checks++; if (rsp_log.size() !== 9) begin failures++; $display("FAIL bp_rsp_count got %0d exp 9", rsp_log.size()); end
        checks++; if (log_adr.size() - l0 !== 9) begin failures++; $display("FAIL bp_bus_count got %0d exp 9", log_adr.size() - l0); end
        n_bad = 0;
        for (int i = 0; i < 9 && l0 + i < log_adr.size(); i++)
            if (log_adr[l0 + i] !== 32'h100 + 32'(4 * i) || mem[32'h100 + 32'(4 * i)] !== 32'hC0DE_0000 + 32'(i)) n_bad++;
        for (int i = 0; i < rsp_log.size(); i++) if (rsp_log[i] !== 33'h0) n_bad++;
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL bp_order got %0d bad entries exp 0", n_bad); end
    endtask

    task automatic test_timeout();
        logic acc, ok;
        ack_lat = 99;
        push(1'b0, 32'h200, 32'h0, acc);
        cycle(1);
        checks++; if (wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL to_launch got %b exp 1", wbm_cyc_o); end
        cycle(3);
        checks++; if (wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL to_early got %b exp 1", wbm_cyc_o); end
        cycle(1);
        checks++; if ({wbm_cyc_o, rsp_valid, rsp_err, rsp_dat} !== {3'b011, 32'h0}) begin failures++; $display("FAIL to_abort got %h exp %h", {wbm_cyc_o, rsp_valid, rsp_err, rsp_dat}, {3'b011, 32'h0}); end
        consume();
        ack_lat = 0;
        push(1'b0, 32'h3000_0010, 32'h0, acc);
        wait_rsp(10, ok);
        checks++; if (!ok || {rsp_err, rsp_dat} !== {1'b0, 32'hA5A5_1234}) begin failures++; $display("FAIL to_recover got %b/%h exp 1/0a5a51234", ok, {rsp_err, rsp_dat}); end
        consume();
    endtask

    task automatic test_ack_timeout_coincide();
        logic acc;
        ack_lat = 3;
        push(1'b0, 32'h3000_0010, 32'h0, acc);
        cycle(4);
        checks++; if (wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL co_early got %b exp 1", wbm_cyc_o); end
        cycle(1);
        checks++; if ({wbm_cyc_o, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'hA5A5_1234}) begin failures++; $display("FAIL co_ack_wins got %h exp %h", {wbm_cyc_o, rsp_valid, rsp_err, rsp_dat}, {3'b010, 32'hA5A5_1234}); end
        consume();
        ack_lat = 0;
    endtask

    task automatic test_mid_reset();
        logic acc;
        int   r0, l0, q0;
        ack_lat = 99;
        push(1'b0, 32'h300, 32'h0, acc);
        push(1'b0, 32'h304, 32'h0, acc);
        push(1'b0, 32'h308, 32'h0, acc);
        checks++; if (wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL mr_inflight got %b exp 1", wbm_cyc_o); end
        wb_rst_i = 1'b1;
        cycle(1);
        wb_rst_i = 1'b0;
        checks++; if ({wbm_cyc_o, wbm_stb_o, busy, rsp_valid} !== 4'b0000) begin failures++; $display("FAIL mr_after got %b exp 0000", {wbm_cyc_o, wbm_stb_o, busy, rsp_valid}); end
        r0 = cyc_rises; l0 = log_adr.size(); q0 = rsp_log.size();
        ack_lat = 0;
        rsp_ready = 1'b1;
        cycle(20);
        rsp_ready = 1'b0;
        checks++; if (cyc_rises - r0 !== 0 || log_adr.size() - l0 !== 0 || rsp_log.size() - q0 !== 0) begin failures++; $display("FAIL mr_flushed got %0d launches %0d responses exp 0 0", cyc_rises - r0, rsp_log.size() - q0); end
    endtask

`ifdef SNN_WB_INIT_ERR_EN
    task automatic test_err_pulse();
        logic acc;
        ack_lat = 99;
        err_lat = 1;
        push(1'b0, 32'h3000_0010, 32'h0, acc);
        cycle(2);
        checks++; if (wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL err_early got %b exp 1", wbm_cyc_o); end
        cycle(1);
        checks++; if ({wbm_cyc_o, rsp_valid, rsp_err, rsp_dat} !== {3'b011, 32'h0}) begin failures++; $display("FAIL err_abort got %h exp %h", {wbm_cyc_o, rsp_valid, rsp_err, rsp_dat}, {3'b011, 32'h0}); end
        consume();
        err_lat = 99;
        ack_lat = 0;
    endtask
`endif

    initial begin
        @(negedge wb_clk_i);
        test_reset();
        test_write_read();
        test_backpressure();
        test_timeout();
        test_ack_timeout_coincide();
`ifdef SNN_WB_INIT_ERR_EN
        test_err_pulse();
`endif
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion exp finish within 100us");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/snn_wb_initiator.md
Name: snn_wb_initiator

Overview:
- Wishbone classic initiator that drives the nvm_neuron_core_256x64 target port from on-chip control logic instead of the management SoC.
- Queues single-word read/write commands in a FIFO and issues them one at a time on the bus.
- Returns one response per command: read data or a timeout error.
- Sits between a spike/weight sequencer and the neuron core Wishbone slave inside the user project area.

Parameters:
- CMD_DEPTH, 8, command FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 255, max cycles spent in BUS waiting for ack before abort; >= 1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  target byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte selects
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_err  out  1  transaction aborted
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data from target
- wbm_ack_i  in  1  target acknowledge
- busy  out  1  high when FIFO is non-empty or FSM is not IDLE

Behaviour:
- Clock and reset are exactly as decided: one clock, wb_clk_i; wb_rst_i is synchronous and active-high.
- Reset values:
  - All wbm_* outputs 0.
  - rsp_valid 0, rsp_dat 0, rsp_err 0, busy 0.
  - cmd_ready 1 from the first cycle after reset.
  - FIFO emptied; FSM in IDLE; timeout counter 0.
- FIFO:
  - cmd_ready = !full.
  - A push occurs on an edge where cmd_valid && cmd_ready.
  - A push and a pop on the same edge are both honoured; count is unchanged.
  - When full, cmd_ready is low; the push is refused and the command must be held by the producer.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Condition: FIFO non-empty at a clock edge.
  - Action on that edge: pop the head entry, load wbm_we/sel/adr/dat from it, set cyc = stb = 1, clear the timeout counter, go to BUS.
  - Latency: a command pushed at edge N into an empty, idle block shows cyc/stb high after edge N+1.
- BUS:
  - All wbm_* outputs are held stable.
  - On an edge where wbm_ack_i = 1:
    - cyc = stb = 0.
    - rsp_dat = wbm_dat_i for reads, 0 for writes.
    - rsp_err = 0, rsp_valid = 1; go to RESP.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT_CYCLES and no ack is present on that edge:
    - cyc = stb = 0.
    - rsp_err = 1, rsp_dat = 0, rsp_valid = 1; go to RESP.
  - If ack and timeout coincide on the same edge, ack wins.
- RESP:
  - rsp_valid, rsp_dat and rsp_err stay stable until an edge where rsp_ready = 1.
  - On that edge rsp_valid = 0 and the FSM returns to IDLE.
  - The next command launches no earlier than the following edge. Minimum spacing between consecutive cyc assertions is 3 cycles with an immediate ack.
- wbm_ack_i outside BUS is ignored; it has no effect on state or outputs.
- Only one outstanding transaction; no pipelining; cyc and stb are always equal.
- Reset mid-operation:
  - cyc/stb drop after the reset edge.
  - The in-flight transaction is discarded with no response.
  - Queued commands are flushed.
- wbm_* outputs keep their last values while cyc = 0; targets must ignore them.

Optional Feature:
- Macro: SNN_WB_INIT_ERR_EN.
- Defined:
  - Adds input port wbm_err_i (1 bit).
  - In BUS, an edge with wbm_err_i = 1 and wbm_ack_i = 0 ends the cycle exactly like a timeout: rsp_err = 1, rsp_dat = 0.
  - If ack and err are both high on the same edge, ack wins.
- Undefined:
  - Port absent.
  - Only the timeout produces rsp_err.

Test Plan:
- Write then read back:
  - Stimulus: push write adr 0x3000_0010, dat 0xA5A5_1234, sel 0xF; target acks 1 cycle after stb. Then push read of the same address; target returns 0xA5A5_1234.
  - Response: write rsp has rsp_dat 0, rsp_err 0; read rsp has rsp_dat 0xA5A5_1234, rsp_err 0. cyc high exactly after edge N+1.
- Backpressure on the command side:
  - Stimulus: hold rsp_ready = 0 and push 9 commands with CMD_DEPTH = 8.
  - Response: one command in flight/RESP plus 8 queued; cmd_ready low on the 10th attempt. Asserting rsp_ready drains all commands in push order.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 4, target never acks.
  - Response: cyc low after 4 cycles in BUS; rsp_err = 1, rsp_dat = 0. A later command executes normally.
- Ack/timeout coincidence:
  - Stimulus: ack arrives on exactly the TIMEOUT_CYCLES-th BUS edge.
  - Response: rsp_err = 0 and the data is captured.
- Mid-cycle reset:
  - Stimulus: 3 commands queued; assert wb_rst_i for 1 cycle while cyc = 1.
  - Response: cyc/stb 0, busy 0 and rsp_valid 0 after the edge; no transactions issued afterwards.
- SNN_WB_INIT_ERR_EN defined:
  - Stimulus: wbm_err_i pulses during a read.
  - Response: rsp_err = 1, rsp_dat = 0, cycle terminated on that edge.
